// File: rtl/sw_ctrl_pkg.sv
// sw_ctrl_pkg: shared state encoding and period sizing for the switch-driven read sequencer.
package sw_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int period_ticks(bit sim, int clk_hz, int ms_hw, int ticks_sim);
    return sim ? ticks_sim : (clk_hz / 1000) * ms_hw;
  endfunction
  function automatic int width_of(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/periodo_tick.sv
// periodo_tick: free-running period counter; tick is high on the last count of each period.
module periodo_tick import sw_ctrl_pkg::*; #(
  parameter int PERIOD_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int CW = width_of(PERIOD_TICKS);
  logic [CW-1:0] cnt;
  assign tick = enable & ~clear & (cnt == CW'(PERIOD_TICKS - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/sw_read_sequencer.sv
// sw_read_sequencer: SW[0] starts/aborts periodic register-read sweeps; SW[1] picks single or continuous.
module sw_read_sequencer import sw_ctrl_pkg::*; #(
  parameter bit Simulacion       = 0,
  parameter int CLK_HZ           = 10_000_000,
  parameter int PERIOD_MS_HW     = 100,
  parameter int PERIOD_TICKS_SIM = 4,
  parameter int N_REGS           = 16,
  localparam int AW              = width_of(N_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sw0_db,
  input  logic          sw0_db_d,
  input  logic          sw1_db,
  input  logic          sw1_db_d,
  output logic          start_pulse,
  output logic          leer,
  output logic [AW-1:0] addr,
  output logic          busy,
  output logic          done
);
  localparam int PT = period_ticks(Simulacion, CLK_HZ, PERIOD_MS_HW, PERIOD_TICKS_SIM);
  state_t state;
  logic mode, tick, rise0, fall0, last, unused_sw1;
  assign rise0 = sw0_db & ~sw0_db_d;
  assign fall0 = ~sw0_db & sw0_db_d;
  // mode is latched at start, so sw1 edges are deliberately not acted on
  assign unused_sw1 = sw1_db ^ sw1_db_d;
  assign last = leer & ~mode & (addr == AW'(N_REGS - 1));
  periodo_tick #(.PERIOD_TICKS(PT)) u_periodo_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != RUN || fall0),
    .enable (state == RUN),
    .tick   (tick)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      mode        <= 1'b0;
      addr        <= '0;
      start_pulse <= 1'b0;
      leer        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      leer        <= 1'b0;
      case (state)
        IDLE: if (rise0) begin
          state       <= RUN;
          start_pulse <= 1'b1;
          busy        <= 1'b1;
          addr        <= '0;
          mode        <= sw1_db;
        end
        RUN: if (fall0) begin
          state <= IDLE;
          busy  <= 1'b0;
          addr  <= '0;
        end else begin
          leer <= tick & ~last;
          if (leer) addr <= addr == AW'(N_REGS - 1) ? '0 : addr + AW'(1);
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: if (fall0) begin
          state <= IDLE;
          done  <= 1'b0;
          addr  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sw_read_sequencer.sv
// tb_sw_read_sequencer: scoreboard bench; expected strobes come from a timing model of the sweep rules.
module tb_sw_read_sequencer;
  localparam int P = 4;
  localparam int N = 4;
  typedef struct {bit st; int cyc; int a;} ev_t;
  logic clk = 0, reset = 1;
  logic sw0_db = 0, sw0_db_d = 0, sw1_db = 0, sw1_db_d = 0;
  logic start_pulse, leer, busy, done;
  logic [1:0] addr;
  int cyc = 0, n_cmp = 0, n_bad = 0, t0 = 0;
  bit running = 0, single = 0, exp_busy = 0, exp_done = 0;
  ev_t q[$];

  sw_read_sequencer #(
    .Simulacion(1), .CLK_HZ(10_000_000), .PERIOD_MS_HW(100),
    .PERIOD_TICKS_SIM(P), .N_REGS(N)
  ) dut (
    .clk(clk), .reset(reset), .sw0_db(sw0_db), .sw0_db_d(sw0_db_d),
    .sw1_db(sw1_db), .sw1_db_d(sw1_db_d), .start_pulse(start_pulse),
    .leer(leer), .addr(addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; the model then predicts what this new cycle must show.
  task automatic step(input bit a, input bit b);
    bit prev;
    int d;
    prev = sw0_db;
    sw0_db_d = sw0_db;
    sw1_db_d = sw1_db;
    sw0_db = a;
    sw1_db = b;
    @(posedge clk);
    #1;
    if (reset) running = 0;
    else if (!running) begin
      if (a && !prev) begin
        running = 1;
        single = !b;
        t0 = cyc;
        q.push_back('{1'b1, cyc, 0});
      end
    end else if (!a && prev) running = 0;
    else begin
      d = cyc - t0;
      if (d > 0 && d % P == 0 && (!single || d / P <= N))
        q.push_back('{1'b0, cyc, (d / P - 1) % N});
    end
    exp_done = running && single && (cyc - t0 > N * P);
    exp_busy = running && !exp_done;
  endtask

  task automatic run(input int n, input bit a, input bit b);
    for (int i = 0; i < n; i++) step(a, b);
  endtask

  task automatic do_reset();
    #2 reset = 1;
    running = 0;
    exp_busy = 0;
    exp_done = 0;
    q.delete();
    #1;
    chk("rst_start", start_pulse, 0);
    chk("rst_leer", leer, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", addr, 0);
    run(2, sw0_db, sw1_db);
    reset = 0;
  endtask

  always @(negedge clk) begin
    ev_t e;
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    if (!exp_busy) chk("addr_idle", addr, 0);
    if (start_pulse && leer) chk("start_and_leer", 1, 0);
    if (start_pulse || leer) begin
      if (q.size() == 0) chk(start_pulse ? "unexpected_start" : "unexpected_leer", 1, 0);
      else begin
        e = q.pop_front();
        chk("strobe_kind", start_pulse, e.st);
        chk("strobe_cycle", cyc, e.cyc);
        if (leer) chk("leer_addr", addr, e.a);
      end
    end
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      chk(e.st ? "missed_start" : "missed_leer", 0, 1);
    end
  end

  initial begin
    @(posedge clk);
    #1;
    chk("init_start", start_pulse, 0);
    chk("init_leer", leer, 0);
    chk("init_addr", addr, 0);
    run(2, 0, 0);
    reset = 0;
    run(3, 0, 0);
    // single sweep to DONE, then hold
    step(1, 0);
    run(24, 1, 0);
    step(0, 0);
    run(3, 0, 0);
    // continuous; sw1 drops mid-run without effect
    step(1, 1);
    run(10, 1, 1);
    run(20, 1, 0);
    step(0, 0);
    run(3, 0, 0);
    // abort on the cycle a tick is due
    step(1, 1);
    run(7, 1, 1);
    step(0, 1);
    run(3, 0, 0);
    // restart guard from DONE
    step(1, 0);
    run(20, 1, 0);
    step(0, 0);
    step(1, 0);
    step(0, 0);
    step(1, 0);
    run(20, 1, 0);
    step(0, 0);
    run(2, 0, 0);
    // reset mid-run after two leer strobes
    step(1, 1);
    run(10, 1, 1);
    do_reset();
    run(12, 1, 1);
    step(0, 0);
    step(1, 0);
    run(20, 1, 0);
    // random switch activity
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 11) == 0 ? !sw0_db : sw0_db,
           $urandom_range(0, 7) == 0 ? !sw1_db : sw1_db);
    step(0, 0);
    run(4, 0, 0);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sw_read_sequencer.md
SW_READ_SEQUENCER -- requirements
Module: sw_read_sequencer

Interface
REQ-001 SHALL have parameter Simulacion, bit, default 0: 1 selects simulation timing.
REQ-002 SHALL have parameter CLK_HZ, int, default 10_000_000: clk frequency in Hz.
REQ-003 SHALL have parameter PERIOD_MS_HW, int, default 100: read period on hardware, in ms.
REQ-004 SHALL have parameter PERIOD_TICKS_SIM, int, default 4: read period in simulation, in cycles.
REQ-005 SHALL have parameter N_REGS, int, default 16: number of registers per sweep.
REQ-006 SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port sw0_db, input, 1 bit: debounced SW[0] (run switch).
REQ-009 SHALL have port sw0_db_d, input, 1 bit: sw0_db delayed one clk.
REQ-010 SHALL have port sw1_db, input, 1 bit: debounced SW[1] (mode: 1 = continuous, 0 = single sweep).
REQ-011 SHALL have port sw1_db_d, input, 1 bit: sw1_db delayed one clk; feeds edge detection only.
REQ-012 SHALL have port start_pulse, output, 1 bit: one-cycle run-start strobe.
REQ-013 SHALL have port leer, output, 1 bit: one-cycle register-read strobe.
REQ-014 SHALL have port addr, output, AW bits: read address; AW = max(1, clog2(N_REGS)).
REQ-015 SHALL have port busy, output, 1 bit: high in RUN.
REQ-016 SHALL have port done, output, 1 bit: high in DONE.

Function
REQ-017 SHALL compute PERIOD_TICKS = Simulacion ? PERIOD_TICKS_SIM : (CLK_HZ/1000)*PERIOD_MS_HW; tick counter width = max(1, clog2(PERIOD_TICKS)).
REQ-018 SHALL detect rise0 = sw0_db & ~sw0_db_d and fall0 = ~sw0_db & sw0_db_d.
REQ-019 SHALL implement an FSM with states IDLE, RUN, DONE; all outputs registered.
REQ-020 IDLE: on rise0, SHALL go to RUN, assert start_pulse the following cycle, clear the tick counter and addr, and latch sw1_db as the mode.
REQ-021 RUN: tick counter SHALL increment each cycle; at PERIOD_TICKS-1 it SHALL wrap to 0 and leer SHALL be high for that one following cycle with addr valid.
REQ-022 First leer SHALL occur exactly PERIOD_TICKS cycles after start_pulse; subsequent leer strobes SHALL be exactly PERIOD_TICKS cycles apart.
REQ-023 addr SHALL hold for the whole leer cycle and increment by 1 on the clock edge that ends it; N_REGS-1 wraps to 0.
REQ-024 Single mode: after the leer with addr = N_REGS-1, the FSM SHALL go to DONE, with addr wrapped to 0.
REQ-025 Continuous mode: sweeps SHALL repeat indefinitely; mode changes on sw1 during RUN SHALL be ignored.
REQ-026 RUN or DONE: on fall0, SHALL go to IDLE next cycle, clear addr and the counter, and issue no leer in that cycle, even if a tick coincides (abort wins).
REQ-027 rise0 while in RUN or DONE SHALL be ignored (no restart).
REQ-028 DONE SHALL be held until fall0.
REQ-029 start_pulse and leer SHALL never be high in the same cycle.

Reset
REQ-030 reset SHALL asynchronously force state IDLE, tick counter 0, addr 0, mode 0, and start_pulse, leer, busy, done all 0.
REQ-031 reset mid-RUN SHALL suppress any pending leer; after release, a new rise0 is required to start.

Structure
REQ-032 Package sw_ctrl_pkg SHALL hold the state enum (IDLE, RUN, DONE) and a function computing PERIOD_TICKS from Simulacion, CLK_HZ, PERIOD_MS_HW and PERIOD_TICKS_SIM.
REQ-033 Period counter SHALL be the sub-module periodo_tick (inputs clk, reset, clear, enable; output tick), instantiated once.

Verification (Simulacion=1, PERIOD_TICKS_SIM=4, N_REGS=4)
REQ-034 Single sweep: sw0 rises with sw1=0 -> start_pulse at cycle T; leer at T+4, T+8, T+12, T+16 with addr 0,1,2,3; done high from T+17; addr=0.
REQ-035 Continuous: sw1=1 at start -> leer continues past addr 3 with addr 0 at T+20; sw1 falling mid-run has no effect.
REQ-036 Abort: sw0 falls in the cycle a tick is due -> no leer, busy=0 and addr=0 next cycle.
REQ-037 Restart guard: sw0 toggled 0->1->0->1 in DONE -> IDLE, then a new start_pulse and a fresh sweep from addr 0.
REQ-038 Reset mid-RUN after 2 leer strobes -> all outputs 0 immediately; no leer after release until a new rise0.
